// File: rtl/dm_pkg.sv
// Shared opcode encodings, response codes, FSM states and op decode for the
// MEM-stage data memory.
package dm_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_OP    = 2'b10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef struct packed {
    logic  legal;
    logic  is_store;
    logic  is_signed;
    size_e size;
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [5:0] op);
    op_dec_t d;
    d.legal     = 1'b1;
    d.is_store  = 1'b0;
    d.is_signed = 1'b0;
    d.size      = SZ_W;
    case (op)
      OP_LB:   begin d.size = SZ_B; d.is_signed = 1'b1; end
      OP_LBU:  d.size = SZ_B;
      OP_LH:   begin d.size = SZ_H; d.is_signed = 1'b1; end
      OP_LHU:  d.size = SZ_H;
      OP_LW:   d.size = SZ_W;
      OP_SB:   begin d.size = SZ_B; d.is_store = 1'b1; end
      OP_SH:   begin d.size = SZ_H; d.is_store = 1'b1; end
      OP_SW:   begin d.size = SZ_W; d.is_store = 1'b1; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic misaligned(input size_e size, input logic [1:0] lo);
    logic m;
    case (size)
      SZ_H:    m = lo[0];
      SZ_W:    m = (lo != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dm_lsu_ram_if.sv
// Request/response bundle between the MEM stage and the data memory, plus an
// optional store-commit trace channel.
interface dm_lsu_ram_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic [5:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              rsp_valid;
  logic [31:0]       rdata;
  logic [1:0]        err;
  logic              trace_valid;
  logic [ADDR_W-1:0] trace_addr;
  logic [3:0]        trace_be;
  logic [31:0]       trace_data;

  modport master (
    output req_valid, op, addr, wdata,
    input  req_ready, rsp_valid, rdata, err,
    input  trace_valid, trace_addr, trace_be, trace_data
  );

  modport slave (
    input  req_valid, op, addr, wdata,
    output req_ready, rsp_valid, rdata, err,
    output trace_valid, trace_addr, trace_be, trace_data
  );
endinterface

// File: rtl/dm_bank.sv
// DEPTH x 32 word array with per-byte write enables and an asynchronous read
// port; the parent registers whatever it needs from the read data.
module dm_bank #(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [2**IDX_W];

  // Byte-enabled write of the addressed word
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (be[k]) begin
        mem_q[idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/dm_lsu_ram.sv
// MEM-stage data memory: clear-after-reset FSM, load/store decode, alignment
// checking, lane steering and a registered one-cycle response.
module dm_lsu_ram
  import dm_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter bit TRACE  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  dm_lsu_ram_if.slave  bus
);

  localparam int IDX_W = ADDR_W - 2;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;
  logic              trace_valid_q, trace_valid_d;
  logic [ADDR_W-1:0] trace_addr_q, trace_addr_d;
  logic [3:0]        trace_be_q, trace_be_d;
  logic [31:0]       trace_data_q, trace_data_d;

  logic [3:0]        bank_be;
  logic [IDX_W-1:0]  bank_idx;
  logic [31:0]       bank_wdata;
  logic [31:0]       bank_rdata;

  op_dec_t           dec;
  logic              misal;
  logic              accept;
  logic [3:0]        lane_be;
  logic [31:0]       lane_data;
  logic [31:0]       rd_shift;
  logic [31:0]       load_val;

  assign dec    = decode_op(bus.op);
  assign misal  = misaligned(dec.size, bus.addr[1:0]);
  assign accept = bus.req_valid && (state_q == ST_RUN);

  // Store lane steering and load extraction/extension
  always_comb begin
    lane_be   = 4'b1111;
    lane_data = bus.wdata;
    // Halfword loads are aligned here, so the byte shift also centres halves.
    rd_shift  = bank_rdata >> {bus.addr[1:0], 3'b000};
    load_val  = bank_rdata;
    case (dec.size)
      SZ_B: begin
        lane_be   = 4'b0001 << bus.addr[1:0];
        lane_data = {4{bus.wdata[7:0]}};
        if (dec.is_signed) begin
          load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
        end else begin
          load_val = {24'd0, rd_shift[7:0]};
        end
      end
      SZ_H: begin
        lane_be   = bus.addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{bus.wdata[15:0]}};
        if (dec.is_signed) begin
          load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
        end else begin
          load_val = {16'd0, rd_shift[15:0]};
        end
      end
      default: begin
        lane_be   = 4'b1111;
        lane_data = bus.wdata;
        load_val  = bank_rdata;
      end
    endcase
  end

  // FSM next state, array port muxing and response computation
  always_comb begin
    state_d       = state_q;
    clr_idx_d     = clr_idx_q;
    rsp_valid_d   = 1'b0;
    rdata_d       = rdata_q;
    err_d         = err_q;
    trace_valid_d = 1'b0;
    trace_addr_d  = trace_addr_q;
    trace_be_d    = trace_be_q;
    trace_data_d  = trace_data_q;
    bank_be       = 4'b0000;
    bank_idx      = bus.addr[ADDR_W-1:2];
    bank_wdata    = lane_data;
    case (state_q)
      ST_CLEAR: begin
        bank_be    = 4'b1111;
        bank_idx   = clr_idx_q;
        bank_wdata = 32'd0;
        clr_idx_d  = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == {IDX_W{1'b1}}) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_RUN: begin
        if (accept) begin
          rsp_valid_d = 1'b1;
          if (!dec.legal) begin
            rdata_d = 32'd0;
            err_d   = ERR_OP;
          end else if (misal) begin
            rdata_d = 32'd0;
            err_d   = ERR_ALIGN;
          end else if (dec.is_store) begin
            bank_be       = lane_be;
            rdata_d       = 32'd0;
            err_d         = ERR_OK;
            trace_valid_d = TRACE;
            trace_addr_d  = bus.addr;
            trace_be_d    = lane_be;
            trace_data_d  = lane_data;
          end else begin
            rdata_d = load_val;
            err_d   = ERR_OK;
          end
        end else begin
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // State and response registers; reset also drops any pending response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_CLEAR;
      clr_idx_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rdata_q       <= 32'd0;
      err_q         <= ERR_OK;
      trace_valid_q <= 1'b0;
      trace_addr_q  <= '0;
      trace_be_q    <= 4'b0000;
      trace_data_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      clr_idx_q     <= clr_idx_d;
      rsp_valid_q   <= rsp_valid_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      trace_valid_q <= trace_valid_d;
      trace_addr_q  <= trace_addr_d;
      trace_be_q    <= trace_be_d;
      trace_data_q  <= trace_data_d;
    end
  end

  dm_bank #(.IDX_W(IDX_W)) u_bank (
    .clk   (clk),
    .be    (bank_be),
    .idx   (bank_idx),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

  assign bus.req_ready   = (state_q == ST_RUN);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rdata       = rdata_q;
  assign bus.err         = err_q;
  assign bus.trace_valid = trace_valid_q;
  assign bus.trace_addr  = trace_addr_q;
  assign bus.trace_be    = trace_be_q;
  assign bus.trace_data  = trace_data_q;

endmodule

// File: tb/tb_dm_lsu_ram.sv
// Directed and randomized bench for dm_lsu_ram against a byte-array memory model.
module tb_dm_lsu_ram;
  import dm_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 2**(ADDR_W-2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]  mem_m [4*DEPTH];
  bit          pend = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  logic [1:0]  exp_err = 2'b00;
  logic [31:0] last_rdata = 32'd0;
  logic [1:0]  last_err = 2'b00;

  dm_lsu_ram_if #(.ADDR_W(ADDR_W)) bus ();

  dm_lsu_ram #(.ADDR_W(ADDR_W), .TRACE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.trace_valid === 1'b1)
      $display("trace: store data=%08h addr=%03h lanes=%04b", bus.trace_data, bus.trace_addr, bus.trace_be);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Reference: memory as little-endian bytes, access size and alignment from the opcode.
  task automatic model(input logic [5:0] o, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic [1:0] e);
    int sz; bit st; bit sg; logic [31:0] v;
    sz = 0; st = 1'b0; sg = 1'b0;
    case (o)
      OP_LB:   begin sz = 1; sg = 1'b1; end
      OP_LBU:  sz = 1;
      OP_LH:   begin sz = 2; sg = 1'b1; end
      OP_LHU:  sz = 2;
      OP_LW:   sz = 4;
      OP_SB:   begin sz = 1; st = 1'b1; end
      OP_SH:   begin sz = 2; st = 1'b1; end
      OP_SW:   begin sz = 4; st = 1'b1; end
      default: sz = 0;
    endcase
    r = 32'd0;
    e = 2'b00;
    if (sz == 0) e = 2'b10;
    else if ((int'(a) % sz) != 0) e = 2'b01;
    else if (st) begin
      for (int i = 0; i < sz; i++) mem_m[int'(a) + i] = d[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < sz; i++) v = v | (32'(mem_m[int'(a) + i]) << (8*i));
      if (sg && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
      r = v;
    end
  endtask

  // Called at a negedge: check the response due now, then present the next request.
  task automatic step(input bit v, input logic [5:0] o, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    logic [31:0] r; logic [1:0] e;
    if (pend) begin
      chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rdata", bus.rdata, exp_rdata);
      chk("err", 32'(bus.err), 32'(exp_err));
      last_rdata = exp_rdata;
      last_err   = exp_err;
    end else begin
      chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("idle_rdata_hold", bus.rdata, last_rdata);
      chk("idle_err_hold", 32'(bus.err), 32'(last_err));
    end
    bus.req_valid = v;
    bus.op        = o;
    bus.addr      = a;
    bus.wdata     = d;
    if (v) begin
      chk("req_ready", 32'(bus.req_ready), 32'd1);
      model(o, a, d, r, e);
      pend = 1'b1; exp_rdata = r; exp_err = e;
    end else begin
      pend = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse reset, check the reset outputs, then time the clear while offering an ignored store.
  task automatic reset_and_clear(input string tag);
    int cnt; bit saw;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rdata"}, bus.rdata, 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
    for (int i = 0; i < 4*DEPTH; i++) mem_m[i] = 8'h00;
    pend = 1'b0; last_rdata = 32'd0; last_err = 2'b00;
    rst = 1'b0;
    bus.req_valid = 1'b1; bus.op = OP_SW; bus.addr = 12'h040; bus.wdata = 32'hFFFF_FFFF;
    cnt = 0; saw = 1'b0;
    while (bus.req_ready !== 1'b1 && cnt < DEPTH + 8) begin
      cnt++;
      if (bus.rsp_valid !== 1'b0) saw = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk({tag, "_clear_cycles"}, 32'(cnt), 32'(DEPTH));
    chk({tag, "_no_rsp_in_clear"}, 32'(saw), 32'd0);
  endtask

  initial begin
    logic [5:0]        ops [9];
    logic [5:0]        o;
    logic [ADDR_W-1:0] a;
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, 6'b000000};
    bus.req_valid = 1'b0; bus.op = 6'd0; bus.addr = '0; bus.wdata = 32'd0;
    repeat (2) @(negedge clk);
    reset_and_clear("rst0");
    step(1'b1, OP_LW, 12'h040, 32'd0);

    for (int i = 0; i < 24; i++) step(1'b1, OP_SW, ADDR_W'($urandom_range(0, 63) * 4), $urandom);
    step(1'b0, 6'd0, '0, 32'd0);
    reset_and_clear("rst1");
    for (int i = 0; i < 8; i++) step(1'b1, OP_LW, ADDR_W'($urandom_range(0, 63) * 4), 32'd0);

    step(1'b1, OP_SW,  12'h010, 32'h8899_AABB);
    step(1'b1, OP_LB,  12'h013, 32'd0);
    step(1'b1, OP_LBU, 12'h013, 32'd0);
    step(1'b1, OP_LH,  12'h012, 32'd0);
    step(1'b1, OP_LHU, 12'h010, 32'd0);
    step(1'b1, OP_SW,  12'h020, 32'd0);
    step(1'b1, OP_SB,  12'h021, 32'h0000_005A);
    step(1'b1, OP_SH,  12'h022, 32'h0000_1234);
    step(1'b1, OP_LW,  12'h020, 32'd0);
    step(1'b1, OP_SW,  12'h004, 32'h0BAD_F00D);
    step(1'b1, OP_SW,  12'h005, 32'hDEAD_BEEF);
    step(1'b1, OP_LW,  12'h004, 32'd0);
    step(1'b1, OP_LH,  12'h003, 32'd0);
    step(1'b1, 6'b000000, 12'h004, 32'h1111_1111);
    step(1'b1, OP_LW,  12'h004, 32'd0);
    step(1'b1, OP_SW,  12'h030, 32'hCAFE_F00D);
    step(1'b1, OP_LW,  12'h030, 32'd0);
    a = ADDR_W'(32'h1000);
    step(1'b1, OP_SW,  a, 32'h1122_3344);
    step(1'b1, OP_LW,  12'h000, 32'd0);
    step(1'b0, 6'd0, '0, 32'd0);

    for (int i = 0; i < 300; i++) begin
      o = ops[$urandom_range(0, 8)];
      if (o == 6'b000000) o = 6'($urandom);
      a = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 127));
      if ($urandom_range(0, 5) == 0) step(1'b0, 6'd0, '0, 32'd0);
      else step(1'b1, o, a, $urandom);
    end

    step(1'b1, OP_LW, 12'h030, 32'd0);
    reset_and_clear("rst_midop");
    step(1'b1, OP_LW, 12'h030, 32'd0);
    step(1'b0, 6'd0, '0, 32'd0);
    step(1'b0, 6'd0, '0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
